// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-computing bitstream multiplier.
package sc_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } sc_state_e;

  localparam int SC_UNIPOLAR = 0;
  localparam int SC_BIPOLAR  = 1;

  function automatic int sc_count_width(input int n);
    return $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sc_popcount.sv
// Combinational population count over one beat of product-stream lanes.
module sc_popcount
  import sc_pkg::*;
#(
  parameter int LANES = 8,
  localparam int PW = sc_count_width(LANES)
) (
  input  logic [LANES-1:0] bits_in,
  output logic [PW-1:0]    count_out
);

  always_comb begin
    count_out = '0;
    for (int i = 0; i < LANES; i++) begin
      count_out = count_out + PW'(bits_in[i]);
    end
  end

endmodule

// File: rtl/sc_bitstream_mul.sv
// Stochastic multiplier: XNOR/AND of two SNG streams, LANES bits per beat,
// accumulated into a ones-count and a signed (bipolar) or plain result.
//
// state | meaning
// IDLE  | waiting for an operand pair, oReady high
// RUN   | consuming LANES product bits per cycle for K beats
// DONE  | result held on oCount/oResult until iReady is seen
module sc_bitstream_mul
  import sc_pkg::*;
#(
  parameter int BITSTREAM = 64,
  parameter int LANES     = 8,
  parameter int BIPOLAR   = 1,
  localparam int CW = sc_count_width(BITSTREAM),
  localparam int K  = BITSTREAM / LANES
) (
  input  logic                 iClk,
  input  logic                 iRst_n,
  input  logic                 iValid,
  output logic                 oReady,
  input  logic [BITSTREAM-1:0] iBitstreamA,
  input  logic [BITSTREAM-1:0] iBitstreamB,
  output logic                 oValid,
  input  logic                 iReady,
  output logic [CW-1:0]        oCount,
  output logic signed [CW:0]   oResult
);

  localparam int PW = sc_count_width(LANES);
  localparam int BW = (K > 1) ? $clog2(K) : 1;
  localparam logic [BW-1:0] LAST_BEAT = BW'(K - 1);

  if (BITSTREAM % LANES != 0) begin : g_bad_lanes
    $error("sc_bitstream_mul: BITSTREAM must be a multiple of LANES");
  end
  if (BIPOLAR != SC_BIPOLAR && BIPOLAR != SC_UNIPOLAR) begin : g_bad_mode
    $error("sc_bitstream_mul: BIPOLAR must be 0 or 1");
  end

  sc_state_e            state_q, state_d;
  logic [BITSTREAM-1:0] a_q, a_d, b_q, b_d;
  logic [CW-1:0]        acc_q, acc_d, count_q, count_d;
  logic [BW-1:0]        beat_q, beat_d;
  logic signed [CW:0]   res_q, res_d;

  logic [LANES-1:0] prod;
  logic [PW-1:0]    pop;
  logic [CW-1:0]    acc_sum;

  // Bipolar streams encode (2p-1); XNOR multiplies them, AND multiplies unipolar ones.
  always_comb begin
    if (BIPOLAR == SC_BIPOLAR) prod = ~(a_q[LANES-1:0] ^ b_q[LANES-1:0]);
    else                       prod = a_q[LANES-1:0] & b_q[LANES-1:0];
  end

  sc_popcount #(.LANES(LANES)) u_pop (
    .bits_in  (prod),
    .count_out(pop)
  );

  assign acc_sum = acc_q + CW'(pop);

  function automatic logic signed [CW:0] to_result(input logic [CW-1:0] cnt);
    if (BIPOLAR == SC_BIPOLAR) return $signed({cnt, 1'b0}) - $signed((CW+1)'(BITSTREAM));
    else                       return $signed({1'b0, cnt});
  endfunction

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    acc_d   = acc_q;
    beat_d  = beat_q;
    count_d = count_q;
    res_d   = res_q;
    oReady  = (state_q == IDLE) || ((state_q == DONE) && iReady);

    case (state_q)
      RUN: begin
        acc_d  = acc_sum;
        a_d    = a_q >> LANES;
        b_d    = b_q >> LANES;
        beat_d = beat_q + BW'(1);
        if (beat_q == LAST_BEAT) begin
          count_d = acc_sum;
          res_d   = to_result(acc_sum);
          beat_d  = '0;
          state_d = DONE;
        end
      end
      DONE: begin
        if (iReady) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase

    // Retiring a result and loading the next pair share one edge.
    if (iValid && oReady) begin
      a_d     = iBitstreamA;
      b_d     = iBitstreamB;
      acc_d   = '0;
      beat_d  = '0;
      state_d = RUN;
    end
  end

  always_ff @(posedge iClk or negedge iRst_n) begin
    if (!iRst_n) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      acc_q   <= '0;
      beat_q  <= '0;
      count_q <= '0;
      res_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      acc_q   <= acc_d;
      beat_q  <= beat_d;
      count_q <= count_d;
      res_q   <= res_d;
    end
  end

  assign oValid  = (state_q == DONE);
  assign oCount  = count_q;
  assign oResult = res_q;

endmodule
